// File: rtl/scale_rshift_sat_if.sv
// Stream bundle for the scaling stage: input beat, output beat, and saturation monitor.
interface scale_rshift_sat_if #(
    parameter int WIDTH_IN      = 16,
    parameter int WIDTH_OUT     = 8,
    parameter int NUM_LANES     = 8,
    parameter int TOTAL_INPUT_W = 2,
    parameter int MAX_SHIFT     = 15
);
    localparam int SW = $clog2(MAX_SHIFT + 1);

    logic                           in_valid;
    logic                           in_ready;
    logic                           in_last;
    logic [WIDTH_IN*NUM_LANES-1:0]  in_data [TOTAL_INPUT_W];
    logic [SW-1:0]                  shift_amt;
    logic                           round_en;
    logic                           sat_en;
    logic                           out_valid;
    logic                           out_ready;
    logic                           out_last;
    logic [WIDTH_OUT*NUM_LANES-1:0] out_data [TOTAL_INPUT_W];
    logic                           out_sat;
    logic                           sat_clr;
    logic [15:0]                    sat_count;

    modport slave (
        input  in_valid, in_last, in_data, shift_amt, round_en, sat_en, out_ready, sat_clr,
        output in_ready, out_valid, out_last, out_data, out_sat, sat_count
    );

    modport master (
        output in_valid, in_last, in_data, shift_amt, round_en, sat_en, out_ready, sat_clr,
        input  in_ready, out_valid, out_last, out_data, out_sat, sat_count
    );
endinterface

// File: rtl/scale_rshift_sat.sv
// Two-stage lane scaler: S1 rounds and arithmetic-shifts, S2 range-checks and clamps or wraps.
// in_ready is combinational from out_ready so the stage sustains one beat per cycle.
module scale_rshift_sat #(
    parameter int WIDTH_IN      = 16,
    parameter int WIDTH_OUT     = 8,
    parameter int NUM_LANES     = 8,
    parameter int TOTAL_INPUT_W = 2,
    parameter int MAX_SHIFT     = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    scale_rshift_sat_if.slave  bus
);
    localparam int SW = $clog2(MAX_SHIFT + 1);
    localparam int TW = WIDTH_IN + 1;
    localparam logic signed [TW-1:0] OUT_MAX = TW'((32'sd1 <<< (WIDTH_OUT - 1)) - 32'sd1);
    localparam logic signed [TW-1:0] OUT_MIN = ~OUT_MAX;

    // One extra bit of headroom so the rounding bias can never overflow the add.
    function automatic logic signed [TW-1:0] scale_lane(
        input logic signed [WIDTH_IN-1:0] x,
        input logic [SW-1:0]              s,
        input logic                       rnd
    );
        logic signed [TW-1:0] xe;
        logic signed [TW-1:0] bias;
        xe = {x[WIDTH_IN-1], x};
        if (rnd && (s != SW'(0))) begin
            bias = TW'(1'b1) << (s - SW'(1));
        end else begin
            bias = '0;
        end
        return (xe + bias) >>> s;
    endfunction

    function automatic logic lane_ovf(input logic signed [TW-1:0] t);
        return (t > OUT_MAX) || (t < OUT_MIN);
    endfunction

    function automatic logic [WIDTH_OUT-1:0] lane_fit(
        input logic signed [TW-1:0] t,
        input logic                 sat
    );
        logic [WIDTH_OUT-1:0] r;
        if (sat && (t > OUT_MAX)) begin
            r = OUT_MAX[WIDTH_OUT-1:0];
        end else if (sat && (t < OUT_MIN)) begin
            r = OUT_MIN[WIDTH_OUT-1:0];
        end else begin
            r = t[WIDTH_OUT-1:0];
        end
        return r;
    endfunction

    logic                           advance_s;
    logic [SW-1:0]                  shift_s;
    logic signed [TW-1:0]           s1_t_s [TOTAL_INPUT_W][NUM_LANES];
    logic [WIDTH_OUT*NUM_LANES-1:0] s2_data_s [TOTAL_INPUT_W];
    logic                           s2_ovf_s;

    logic signed [TW-1:0]           s1_t_r [TOTAL_INPUT_W][NUM_LANES];
    logic                           s1_valid_r;
    logic                           s1_last_r;
    logic                           s1_sat_en_r;
    logic                           out_valid_r;
    logic                           out_last_r;
    logic                           out_sat_r;
    logic [WIDTH_OUT*NUM_LANES-1:0] out_data_r [TOTAL_INPUT_W];
    logic [15:0]                    sat_count_r;

    assign advance_s = !out_valid_r || bus.out_ready;

    // Clamp the requested shift and scale every incoming lane.
    always_comb begin
        if (bus.shift_amt > SW'(MAX_SHIFT)) begin
            shift_s = SW'(MAX_SHIFT);
        end else begin
            shift_s = bus.shift_amt;
        end
        for (int r = 0; r < TOTAL_INPUT_W; r++) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                s1_t_s[r][l] = scale_lane(bus.in_data[r][l*WIDTH_IN +: WIDTH_IN], shift_s, bus.round_en);
            end
        end
    end

    // Range-check S1 lanes and produce the narrowed output plus the beat-wide overflow flag.
    always_comb begin
        s2_ovf_s = 1'b0;
        for (int r = 0; r < TOTAL_INPUT_W; r++) begin
            s2_data_s[r] = '0;
            for (int l = 0; l < NUM_LANES; l++) begin
                s2_data_s[r][l*WIDTH_OUT +: WIDTH_OUT] = lane_fit(s1_t_r[r][l], s1_sat_en_r);
                s2_ovf_s = s2_ovf_s | lane_ovf(s1_t_r[r][l]);
            end
        end
    end

    // Pipeline registers; everything freezes while the output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r  <= 1'b0;
            s1_last_r   <= 1'b0;
            s1_sat_en_r <= 1'b0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_sat_r   <= 1'b0;
            for (int r = 0; r < TOTAL_INPUT_W; r++) begin
                out_data_r[r] <= '0;
                for (int l = 0; l < NUM_LANES; l++) begin
                    s1_t_r[r][l] <= '0;
                end
            end
        end else if (advance_s) begin
            s1_valid_r  <= bus.in_valid;
            out_valid_r <= s1_valid_r;
            if (bus.in_valid) begin
                s1_t_r      <= s1_t_s;
                s1_last_r   <= bus.in_last;
                s1_sat_en_r <= bus.sat_en;
            end
            if (s1_valid_r) begin
                out_data_r <= s2_data_s;
                out_last_r <= s1_last_r;
                out_sat_r  <= s2_ovf_s;
            end
        end
    end

    // Saturating count of overflowed beats actually handed downstream; clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count_r <= 16'h0000;
        end else if (bus.sat_clr) begin
            sat_count_r <= 16'h0000;
        end else if (out_valid_r && bus.out_ready && out_sat_r && (sat_count_r != 16'hFFFF)) begin
            sat_count_r <= sat_count_r + 16'h0001;
        end
    end

    assign bus.in_ready  = advance_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_last  = out_last_r;
    assign bus.out_sat   = out_sat_r;
    assign bus.out_data  = out_data_r;
    assign bus.sat_count = sat_count_r;
endmodule

// File: tb/tb_scale_rshift_sat.sv
// Scoreboard bench for scale_rshift_sat: directed beats push expectations, a monitor checks transfers.
module tb_scale_rshift_sat;
    typedef logic [129:0] exp_t;  // {last, sat, row1[63:0], row0[63:0]}

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    logic bp_on = 1'b0;
    int   bp_cyc = 0;

    scale_rshift_sat_if #(.WIDTH_IN(16), .WIDTH_OUT(8), .NUM_LANES(8),
                          .TOTAL_INPUT_W(2), .MAX_SHIFT(15)) bus();

    scale_rshift_sat #(.WIDTH_IN(16), .WIDTH_OUT(8), .NUM_LANES(8),
                       .TOTAL_INPUT_W(2), .MAX_SHIFT(15)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic set_ready();
        bus.out_ready = !(bp_on && bp_cyc >= 3 && bp_cyc <= 5);
        bp_cyc++;
    endtask

    // v0 goes to row0 lane0, v1 to row1 lane7; all other lanes are zero.
    task automatic send(input logic [15:0] v0, input logic [15:0] v1, input logic [3:0] sh,
                        input logic rnd, input logic sat, input logic last,
                        input logic [7:0] e0, input logic [7:0] e1, input logic es);
        logic acc;
        int   n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            bus.in_valid   = 1'b1;
            bus.in_data[0] = {112'h0, v0};
            bus.in_data[1] = {v1, 112'h0};
            bus.shift_amt  = sh;
            bus.round_en   = rnd;
            bus.sat_en     = sat;
            bus.in_last    = last;
            set_ready();
            #1;
            acc = bus.in_ready;
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0");
        end else begin
            q.push_back({last, es, e1, 56'h0, 56'h0, e0});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
            bus.sat_clr  = 1'b0;
            set_ready();
        end
    endtask

    // Monitor: pops on every transfer, and checks stall stability and in_ready during stalls.
    initial begin : monitor
        exp_t held;
        exp_t act;
        exp_t e;
        logic held_valid;
        held_valid = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                held_valid = 1'b0;
            end else begin
                act = {bus.out_last, bus.out_sat, bus.out_data[1], bus.out_data[0]};
                if (held_valid) begin
                    checks++;
                    if (act !== held) begin
                        errors++;
                        $display("FAIL stall_stable: got %h expected %h", act, held);
                    end
                end
                if (bus.out_valid && !bus.out_ready) begin
                    check("in_ready_stall", {31'h0, bus.in_ready}, 32'h0);
                    held_valid = 1'b1;
                    held = act;
                end else begin
                    held_valid = 1'b0;
                end
                if (bus.out_valid && bus.out_ready) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat: got %h expected none", act);
                    end else begin
                        e = q.pop_front();
                        if (act !== e) begin
                            errors++;
                            $display("FAIL beat: got %h expected %h", act, e);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_data[0] = '0;
        bus.in_data[1] = '0;
        bus.shift_amt = 4'd0;
        bus.round_en  = 1'b0;
        bus.sat_en    = 1'b0;
        bus.out_ready = 1'b1;
        bus.sat_clr   = 1'b0;
        #12;
        check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("rst_out_data", bus.out_data[0][31:0] | bus.out_data[1][63:32], 32'h0);
        check("rst_out_last_sat", {30'h0, bus.out_last, bus.out_sat}, 32'h0);
        check("rst_sat_count", {16'h0, bus.sat_count}, 32'h0);
        check("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Floor, rounding, saturation and wrap at shift 4.
        send(16'h0123, 16'hFEDD, 4'd4, 1'b0, 1'b1, 1'b0, 8'h12, 8'hED, 1'b0);
        send(16'h0018, 16'hFFE8, 4'd4, 1'b1, 1'b1, 1'b0, 8'h02, 8'hFF, 1'b0);
        send(16'h0018, 16'hFFE8, 4'd4, 1'b0, 1'b1, 1'b0, 8'h01, 8'hFE, 1'b0);
        send(16'h7FFF, 16'h8000, 4'd4, 1'b0, 1'b1, 1'b0, 8'h7F, 8'h80, 1'b1);
        send(16'h7FFF, 16'h8000, 4'd4, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b1);
        idle(5);
        check("sat_count_2", {16'h0, bus.sat_count}, 32'd2);

        // Shift 0 ignores rounding; shift 15 rounds half up.
        send(16'h0005, 16'h0080, 4'd0, 1'b1, 1'b1, 1'b0, 8'h05, 8'h7F, 1'b1);
        send(16'h4000, 16'hC000, 4'd15, 1'b1, 1'b1, 1'b0, 8'h01, 8'h00, 1'b0);
        idle(5);
        check("sat_count_3", {16'h0, bus.sat_count}, 32'd3);

        // Backpressure: out_ready low on cycles 3..5 of the burst.
        bp_on = 1'b1;
        bp_cyc = 0;
        for (int k = 1; k <= 6; k++) begin
            send(16'(k << 4), 16'h0000, 4'd4, 1'b0, 1'b1, (k == 6), 8'(k), 8'h00, 1'b0);
        end
        idle(8);
        bp_on = 1'b0;
        check("sat_count_bp", {16'h0, bus.sat_count}, 32'd3);

        // Clear coincident with a saturating transfer: clear wins.
        send(16'h7FFF, 16'h0000, 4'd4, 1'b0, 1'b1, 1'b0, 8'h7F, 8'h00, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.out_ready = 1'b1;
            #1;
            if (bus.out_valid) begin
                bus.sat_clr = 1'b1;
                break;
            end
        end
        @(negedge clk);
        bus.sat_clr = 1'b0;
        #1;
        check("sat_clr_wins", {16'h0, bus.sat_count}, 32'd0);

        // Counter ceiling.
        @(negedge clk);
        force dut.sat_count_r = 16'hFFFE;
        #1;
        release dut.sat_count_r;
        #1;
        check("preload_fffe", {16'h0, bus.sat_count}, 32'h0000FFFE);
        send(16'h7FFF, 16'h0000, 4'd4, 1'b0, 1'b1, 1'b0, 8'h7F, 8'h00, 1'b1);
        idle(4);
        check("count_ffff", {16'h0, bus.sat_count}, 32'h0000FFFF);
        send(16'h7FFF, 16'h0000, 4'd4, 1'b0, 1'b1, 1'b0, 8'h7F, 8'h00, 1'b1);
        idle(4);
        check("count_hold_ffff", {16'h0, bus.sat_count}, 32'h0000FFFF);

        // Reset with two beats in flight.
        send(16'h0010, 16'h0000, 4'd4, 1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 1'b0);
        send(16'h0020, 16'h0000, 4'd4, 1'b0, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        q.delete();
        check("midrst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("midrst_in_ready", {31'h0, bus.in_ready}, 32'h1);
        check("midrst_sat_count", {16'h0, bus.sat_count}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        send(16'h0030, 16'h0000, 4'd4, 1'b0, 1'b1, 1'b1, 8'h03, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("lat_edge1_no_valid", {31'h0, bus.out_valid}, 32'h0);
        @(posedge clk);
        #1;
        check("lat_edge2_valid", {31'h0, bus.out_valid}, 32'h1);
        idle(6);
        check("queue_drained", q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
